// File: rtl/ram_led_scanner_pkg.sv
// Shared types and helpers for the RAM-to-LED scanner.
package ram_led_scanner_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WAIT  = 2'd2,
      S_DWELL = 2'd3
   } scan_state_t;

   localparam int DEF_DWELL_50MHZ = 25000000;

   // Width of a counter spanning 0..n-1; never narrower than one bit.
   function automatic int dwell_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_led_scanner_if.sv
// Scanner bus: RAM read port, LED output and status/control.
// SCANNER_MANUAL_STEP_EN adds the step request line.
interface ram_led_scanner_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 10
);
   logic              en;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd_en;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] leds;
   logic              busy;
   logic              frame_done;
`ifdef SCANNER_MANUAL_STEP_EN
   logic              step;

   modport master (input en, ram_rdata, step,
                   output ram_addr, ram_rd_en, leds, busy, frame_done);
   modport slave  (output en, ram_rdata, step,
                   input ram_addr, ram_rd_en, leds, busy, frame_done);
`else
   modport master (input en, ram_rdata,
                   output ram_addr, ram_rd_en, leds, busy, frame_done);
   modport slave  (output en, ram_rdata,
                   input ram_addr, ram_rd_en, leds, busy, frame_done);
`endif
endinterface

// File: rtl/ram_led_scanner_dwell_timer.sv
// Dwell counter: runs 0..DWELL-1 while run is high, pulses expire on the last count.
module dwell_timer
   import ram_led_scanner_pkg::*;
#(
   parameter int DWELL = DEF_DWELL_50MHZ
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expire
);
   localparam int           CW   = dwell_cnt_w(DWELL);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear)    cnt_d = '0;
      else if (run) cnt_d = expire ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ram_led_scanner.sv
// Walks RAM addresses, shows each word on the LEDs for a dwell period.
// SCANNER_MANUAL_STEP_EN: advance on a synchronised step edge instead of the timer.
module ram_led_scanner
   import ram_led_scanner_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 10,
   parameter int RD_LAT = 1,
   parameter int DWELL  = DEF_DWELL_50MHZ
) (
   input logic              clk,
   input logic              reset,
   ram_led_scanner_if.master bus
);
   generate
      if (ADDR_W < 1) begin : g_bad_addr
         $error("ram_led_scanner: ADDR_W must be >= 1");
      end
      if (RD_LAT < 1) begin : g_bad_lat
         $error("ram_led_scanner: RD_LAT must be >= 1");
      end
      if (DWELL < 1) begin : g_bad_dwell
         $error("ram_led_scanner: DWELL must be >= 1");
      end
   endgenerate

   localparam int               LW        = dwell_cnt_w(RD_LAT);
   localparam logic [LW-1:0]     LAT_LAST  = LW'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   scan_state_t       state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] leds_q;
   logic [LW-1:0]     lat_q;
   logic              rd_en_q, busy_q, fd_q;
   logic              advance;

`ifdef SCANNER_MANUAL_STEP_EN
   logic [1:0] step_sync_q;
   logic       step_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_sync_q <= '0;
         step_prev_q <= 1'b0;
      end else begin
         step_sync_q <= {step_sync_q[0], bus.step};
         step_prev_q <= step_sync_q[1];
      end
   end

   // Edges arriving outside DWELL are simply not acted on.
   assign advance = (state_q == S_DWELL) && step_sync_q[1] && !step_prev_q;
`else
   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_q != S_DWELL),
      .run    ((state_q == S_DWELL) && bus.en),
      .expire (advance)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         leds_q  <= '0;
         lat_q   <= '0;
         rd_en_q <= 1'b0;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         fd_q    <= 1'b0;
         case (state_q)
            S_IDLE: if (bus.en) begin
               state_q <= S_READ;
               rd_en_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            S_READ: begin
               state_q <= S_WAIT;
               lat_q   <= '0;
            end
            // An in-flight read always lands, even if en dropped meanwhile.
            S_WAIT: if (lat_q == LAT_LAST) begin
               leds_q <= bus.ram_rdata;
               if (bus.en) state_q <= S_DWELL;
               else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end else begin
               lat_q <= lat_q + 1'b1;
            end
            S_DWELL: if (!bus.en) begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end else if (advance) begin
               addr_q  <= addr_q + 1'b1;
               fd_q    <= (addr_q == ADDR_LAST);
               state_q <= S_READ;
               rd_en_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.ram_addr   = addr_q;
   assign bus.ram_rd_en  = rd_en_q;
   assign bus.leds       = leds_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_ram_led_scanner.sv
// Directed bench for ram_led_scanner (ADDR_W=2, DWELL=4, RAM word[i]=10'h3A0+i).
module tb_ram_led_scanner;
   logic clk;
   logic reset;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   int   fd_cnt   = 0;
   int   fd_dbl   = 0;
   bit   fd_prev  = 1'b0;

   ram_led_scanner_if #(.ADDR_W(2), .DATA_W(10)) bus ();

   ram_led_scanner #(.ADDR_W(2), .DATA_W(10), .RD_LAT(1), .DWELL(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency RAM model
   always @(posedge clk or posedge reset) begin
      if (reset) bus.ram_rdata <= '0;
      else if (bus.ram_rd_en) bus.ram_rdata <= 10'h3A0 + 10'(bus.ram_addr);
   end

   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) begin
         fd_cnt++;
         if (fd_prev) fd_dbl++;
      end
      fd_prev = (bus.frame_done === 1'b1);
   end

   // Advance to the next read strobe; cyc = negedges taken, ok = strobe seen.
   task automatic wait_rd(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.ram_rd_en === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      bus.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_cnt++;
         if ({bus.leds, bus.ram_addr, bus.busy, bus.ram_rd_en, bus.frame_done} !== 15'd0)
            $display("FAIL reset_hold: leds=%h addr=%0d busy=%b rd=%b fd=%b want all 0",
                     bus.leds, bus.ram_addr, bus.busy, bus.ram_rd_en, bus.frame_done);
         else pass_cnt++;
      end
   endtask

   task automatic test_first_read();
      bit ok; int cyc;
      reset = 1'b0;
      wait_rd(ok, cyc);
      chk_cnt++;
      if (!ok || cyc !== 1 || bus.ram_addr !== 2'd0 || bus.busy !== 1'b1)
         $display("FAIL first_rd: ok=%b cyc=%0d addr=%0d busy=%b want 1/1/0/1", ok, cyc, bus.ram_addr, bus.busy);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h000) $display("FAIL first_wait_leds: got %h want 000", bus.leds);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h3A0) $display("FAIL first_leds: got %h want 3a0", bus.leds);
      else pass_cnt++;
      wait_rd(ok, cyc);
      chk_cnt++;
      if (!ok || cyc !== 4 || bus.ram_addr !== 2'd1)
         $display("FAIL dwell_len: ok=%b cyc=%0d addr=%0d want 1/4/1", ok, cyc, bus.ram_addr);
      else pass_cnt++;
   endtask

   task automatic test_frame();
      bit ok; int cyc; int base;
      logic [1:0] a;
      base = fd_cnt;
      for (int k = 1; k <= 4; k++) begin
         a = 2'(k);
         if (k > 1) begin
            wait_rd(ok, cyc);
            chk_cnt++;
            if (!ok || cyc !== 4) $display("FAIL frame_period: ok=%b cyc=%0d want 1/4", ok, cyc);
            else pass_cnt++;
         end
         chk_cnt++;
         if (bus.ram_addr !== a) $display("FAIL frame_addr: got %0d want %0d", bus.ram_addr, a);
         else pass_cnt++;
         if (k == 4) begin
            chk_cnt++;
            if (bus.frame_done !== 1'b1) $display("FAIL frame_done_wrap: got %b want 1", bus.frame_done);
            else pass_cnt++;
         end
         @(negedge clk);
         @(negedge clk);
         chk_cnt++;
         if (bus.leds !== 10'h3A0 + 10'(a)) $display("FAIL frame_leds: got %h want %h", bus.leds, 10'h3A0 + 10'(a));
         else pass_cnt++;
      end
      chk_cnt++;
      if (fd_cnt - base !== 1 || fd_dbl !== 0)
         $display("FAIL frame_done_cnt: pulses=%0d doubles=%0d want 1/0", fd_cnt - base, fd_dbl);
      else pass_cnt++;
   endtask

   task automatic test_en_drop();
      bit ok; int cyc; bit seen_rd;
      for (int k = 0; k < 2; k++) begin
         wait_rd(ok, cyc);
         @(negedge clk);
         @(negedge clk);
      end
      @(negedge clk);
      chk_cnt++;
      if (bus.ram_addr !== 2'd2 || bus.leds !== 10'h3A2)
         $display("FAIL drop_setup: addr=%0d leds=%h want 2/3a2", bus.ram_addr, bus.leds);
      else pass_cnt++;
      bus.en = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (bus.busy !== 1'b0 || bus.leds !== 10'h3A2 || bus.ram_addr !== 2'd2)
         $display("FAIL drop_idle: busy=%b leds=%h addr=%0d want 0/3a2/2", bus.busy, bus.leds, bus.ram_addr);
      else pass_cnt++;
      seen_rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.ram_rd_en === 1'b1) seen_rd = 1'b1;
      end
      chk_cnt++;
      if (seen_rd || bus.ram_addr !== 2'd2 || bus.leds !== 10'h3A2)
         $display("FAIL drop_hold: rd_seen=%b addr=%0d leds=%h want 0/2/3a2", seen_rd, bus.ram_addr, bus.leds);
      else pass_cnt++;
      bus.en = 1'b1;
      wait_rd(ok, cyc);
      chk_cnt++;
      if (!ok || cyc !== 1 || bus.ram_addr !== 2'd2)
         $display("FAIL resume_rd: ok=%b cyc=%0d addr=%0d want 1/1/2", ok, cyc, bus.ram_addr);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h3A2) $display("FAIL resume_leds: got %h want 3a2", bus.leds);
      else pass_cnt++;
      wait_rd(ok, cyc);
      chk_cnt++;
      if (!ok || cyc !== 4 || bus.ram_addr !== 2'd3)
         $display("FAIL resume_dwell: ok=%b cyc=%0d addr=%0d want 1/4/3", ok, cyc, bus.ram_addr);
      else pass_cnt++;
   endtask

   task automatic test_reset_in_wait();
      bit ok; int cyc;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         wait_rd(ok, cyc);
         if (k == 0) begin
            @(negedge clk);
            @(negedge clk);
         end
      end
      chk_cnt++;
      if (!ok || bus.ram_addr !== 2'd1) $display("FAIL rst_setup: ok=%b addr=%0d want 1/1", ok, bus.ram_addr);
      else pass_cnt++;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.leds, bus.ram_addr, bus.busy, bus.ram_rd_en, bus.frame_done} !== 15'd0)
         $display("FAIL rst_async: leds=%h addr=%0d busy=%b rd=%b want all 0",
                  bus.leds, bus.ram_addr, bus.busy, bus.ram_rd_en);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h000 || bus.ram_addr !== 2'd0 || bus.ram_rd_en !== 1'b1)
         $display("FAIL rst_release: leds=%h addr=%0d rd=%b want 000/0/1", bus.leds, bus.ram_addr, bus.ram_rd_en);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h000) $display("FAIL rst_no_stale: got %h want 000", bus.leds);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h3A0) $display("FAIL rst_fresh_read: got %h want 3a0", bus.leds);
      else pass_cnt++;
   endtask

`ifdef SCANNER_MANUAL_STEP_EN
   task automatic test_manual_step();
      bit ok; int cyc;
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h3A0 || bus.ram_addr !== 2'd0 || bus.busy !== 1'b1)
         $display("FAIL step_idle_hold: leds=%h addr=%0d busy=%b want 3a0/0/1", bus.leds, bus.ram_addr, bus.busy);
      else pass_cnt++;
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      wait_rd(ok, cyc);
      chk_cnt++;
      if (!ok || bus.ram_addr !== 2'd1) $display("FAIL step_rd: ok=%b addr=%0d want 1/1", ok, bus.ram_addr);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      chk_cnt++;
      if (bus.leds !== 10'h3A1) $display("FAIL step_leds: got %h want 3a1", bus.leds);
      else pass_cnt++;
   endtask
`endif

   initial begin
      reset  = 1'b1;
      bus.en = 1'b1;
`ifdef SCANNER_MANUAL_STEP_EN
      bus.step = 1'b0;
      test_reset();
      test_manual_step();
`else
      test_reset();
      test_first_read();
      test_frame();
      test_en_drop();
      test_reset_in_wait();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
